// File: rtl/sum_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined add/subtract unit.
package sum_pipe_pkg;

  typedef enum logic {
    SUM_ADD = 1'b0,
    SUM_SUB = 1'b1
  } sum_mode_e;

  // Returns 0 when the stage count is illegal so the caller can reject it.
  function automatic int sum_chunk_w(input int size_data, input int num_stage);
    if (num_stage < 1) return 0;
    if ((size_data % num_stage) != 0) return 0;
    return size_data / num_stage;
  endfunction

endpackage

// File: rtl/sum_pipe_sum_unit.sv
// SUM_unit: combinational chunk adder, {o_carry, o_sum} = a + b + carry-in.
module SUM_unit #(
  parameter int SIZE_DATA = 8
) (
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  input  logic                 i_carry,
  output logic [SIZE_DATA-1:0] o_sum,
  output logic                 o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_data_a} + {1'b0, i_data_b}
                          + {{SIZE_DATA{1'b0}}, i_carry};

endmodule

// File: rtl/sum_pipe_unit.sv
// sum_pipe_unit: chunked add/subtract, one chunk per stage, valid/ready with full stall.
// Signed overflow output is built only when SUM_PIPE_OVF_EN is defined; otherwise tied to 0.
module sum_pipe_unit
  import sum_pipe_pkg::*;
#(
  parameter int SIZE_DATA = 24,
  parameter int NUM_STAGE = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_sub,
  input  logic                 i_carry,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_sum,
  output logic                 o_carry,
  output logic                 o_overflow
);

  localparam int CW   = sum_chunk_w(SIZE_DATA, NUM_STAGE);
  localparam int LAST = NUM_STAGE - 1;

  if (CW < 1 || CW * NUM_STAGE != SIZE_DATA) begin : g_param_err
    $error("sum_pipe_unit: NUM_STAGE must be >= 1 and divide SIZE_DATA");
  end

  sum_mode_e            mode;
  logic [SIZE_DATA-1:0] b_eff;
  logic                 cin_eff;
  logic                 adv;

  assign mode    = sum_mode_e'(i_sub);
  assign b_eff   = (mode == SUM_SUB) ? ~i_data_b : i_data_b;
  assign cin_eff = (mode == SUM_SUB) ? ~i_carry : i_carry;
  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;

  // Stage k sees only the operand chunks not yet consumed (IW bits) and
  // accumulates finished result chunks below its own (RW bits).
  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stg
    localparam int IW = SIZE_DATA - k * CW;
    localparam int RW = (k + 1) * CW;

    logic [IW-1:0] a_in, b_in;
    logic          c_in, v_in, c_out;
    logic [CW-1:0] s_chunk;
    logic [RW-1:0] r_nxt, r_q;
    logic          v_q, c_q;

    if (k == 0) begin : g_src
      assign a_in  = i_data_a;
      assign b_in  = b_eff;
      assign c_in  = cin_eff;
      assign v_in  = i_valid;
      assign r_nxt = s_chunk;
    end else begin : g_src
      assign a_in  = g_stg[k-1].g_fwd.a_q;
      assign b_in  = g_stg[k-1].g_fwd.b_q;
      assign c_in  = g_stg[k-1].c_q;
      assign v_in  = g_stg[k-1].v_q;
      assign r_nxt = {s_chunk, g_stg[k-1].r_q};
    end

    SUM_unit #(.SIZE_DATA(CW)) u_add (
      .i_data_a (a_in[CW-1:0]),
      .i_data_b (b_in[CW-1:0]),
      .i_carry  (c_in),
      .o_sum    (s_chunk),
      .o_carry  (c_out)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= c_out;
        r_q <= r_nxt;
      end
    end

    if (k < LAST) begin : g_fwd
      logic [IW-CW-1:0] a_q, b_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[IW-1:CW];
          b_q <= b_in[IW-1:CW];
        end
      end
    end

`ifdef SUM_PIPE_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    if (k == LAST) begin : g_ovf
      logic ovf_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
          ovf_q <= 1'b0;
        else if (adv)
          ovf_q <= c_out ^ (a_in[CW-1] ^ b_in[CW-1] ^ s_chunk[CW-1]);
      end
    end
`endif
  end

  assign o_valid = g_stg[LAST].v_q;
  assign o_sum   = g_stg[LAST].r_q;
  assign o_carry = g_stg[LAST].c_q;

`ifdef SUM_PIPE_OVF_EN
  assign o_overflow = g_stg[LAST].g_ovf.ovf_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sum_pipe_unit.sv
// Scoreboard bench for sum_pipe_unit at SIZE_DATA=8, NUM_STAGE=2.
module tb_sum_pipe_unit;

  localparam int SD = 8;
  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, i_sub, i_carry, i_ready;
  logic [SD-1:0] i_data_a, i_data_b;
  logic          o_ready, o_valid, o_carry, o_overflow;
  logic [SD-1:0] o_sum;

  always #5 clk = ~clk;

  sum_pipe_unit #(.SIZE_DATA(SD), .NUM_STAGE(NS)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_sub      (i_sub),
    .i_carry    (i_carry),
    .i_data_a   (i_data_a),
    .i_data_b   (i_data_b),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sum      (o_sum),
    .o_carry    (o_carry),
    .o_overflow (o_overflow)
  );

  typedef struct {
    logic [SD-1:0] sum;
    logic          carry;
    logic          ovf;
    int            t;
    int            snap;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic gate_ovf(input logic ovf);
`ifdef SUM_PIPE_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: {carry, sum} = A + B' + cin; overflow from operand/result sign bits.
  function automatic logic [SD+1:0] model(input logic sub, input logic cin,
                                          input logic [SD-1:0] a, input logic [SD-1:0] b);
    logic [SD-1:0] bb;
    logic          c;
    logic [SD:0]   full;
    logic          ovf;
    bb   = sub ? ~b : b;
    c    = sub ? ~cin : cin;
    full = {1'b0, a} + {1'b0, bb} + {{SD{1'b0}}, c};
    ovf  = (a[SD-1] == bb[SD-1]) && (full[SD-1] != a[SD-1]);
    return {full, gate_ovf(ovf)};
  endfunction

  task automatic step(input logic v, input logic sub, input logic cin,
                      input logic [SD-1:0] a, input logic [SD-1:0] b, input logic rdy,
                      input logic [SD-1:0] esum, input logic ecarry, input logic eovf,
                      output logic acc);
    exp_t e;
    @(negedge clk);
    i_valid  = v;
    i_sub    = sub;
    i_carry  = cin;
    i_data_a = a;
    i_data_b = b;
    i_ready  = rdy;
    #1;
    acc = v && o_ready;
    if (acc) begin
      e.sum   = esum;
      e.carry = ecarry;
      e.ovf   = eovf;
      e.t     = cyc + 1;
      e.snap  = stall_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b0, 1'b0, acc);
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && o_valid) begin
      check("valid_has_expect", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb[0];
        check("sum", o_sum, e.sum);
        check("carry", o_carry, e.carry);
        check("overflow", o_overflow, e.ovf);
        if (i_ready) begin
          check("latency", cyc, e.t + (NS - 1) + (stall_cnt - e.snap));
          void'(sb.pop_front());
        end else begin
          check("ready_in_stall", o_ready, 0);
          stall_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic          acc;
  logic [SD+1:0] m;
  int            idx;
  logic          s_sub [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic          s_cin [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [SD-1:0] s_a   [6] = '{8'h10, 8'h80, 8'h40, 8'h00, 8'hAA, 8'h7F};
  logic [SD-1:0] s_b   [6] = '{8'h20, 8'h01, 8'h40, 8'h00, 8'h55, 8'h80};

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_sub = 1'b0; i_carry = 1'b0;
    i_data_a = '0; i_data_b = '0; i_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_sum", o_sum, 8'h00);
    check("rst_carry", o_carry, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_ready", o_ready, 1);
    #2 rst_n = 1'b1;

    step(1'b0, 1'b0, 1'b0, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, acc);
    step(1'b1, 1'b0, 1'b0, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, acc);
    check("accept_add_wrap", acc, 1);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, acc);
    check("accept_sub_borrow", acc, 1);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, gate_ovf(1'b1), acc);
    check("accept_add_ovf", acc, 1);
    idle(3);

    // Back-to-back stream with a 3-cycle downstream stall in the middle.
    idx = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      m = model(s_sub[idx], s_cin[idx], s_a[idx], s_b[idx]);
      step(1'b1, s_sub[idx], s_cin[idx], s_a[idx], s_b[idx], !(c >= 3 && c < 6),
           m[SD:1], m[SD+1], m[0], acc);
      if (acc) idx++;
    end
    check("stream_issued", idx, 6);
    idle(4);
    check("stream_drained", sb.size(), 0);

    // Asynchronous reset with two operations in flight.
    step(1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 1'b1, 8'h50, 8'h10, 1'b0, 8'h3F, 1'b1, 1'b0, acc);
    @(negedge clk);
    i_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_sum", o_sum, 8'h00);
    check("midrst_ready", o_ready, 1);
    sb.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    idle(3);
    step(1'b1, 1'b0, 1'b1, 8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0, acc);
    check("accept_after_rst", acc, 1);
    idle(4);
    check("final_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
